multi_cycle_unit: RTL and testbench
===================================

MULTI_CYCLE_UNIT -- requirements
Module: multi_cycle_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits (legal range 8..64, even).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin an operation, sampled only in IDLE.
REQ-005 SHALL have port flush  input  1  exception flush, aborts any operation.
REQ-006 SHALL have port op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
REQ-007 SHALL have port op1  input  WIDTH  first operand (multiplicand / dividend).
REQ-008 SHALL have port op2  input  WIDTH  second operand (multiplier / divisor).
REQ-009 SHALL have port hilo_i  input  2*WIDTH  accumulator input for MADD/MSUB.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port result  output  2*WIDTH  {hi, lo} result.
REQ-013 SHALL have port div0  output  1  set with done when a DIV/DIVU had op2 == 0.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE; transitions IDLE->CALC on start & !flush; CALC->FIX after WIDTH iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-015 SHALL capture op, op1, op2, hilo_i at the accepting edge; later input changes SHALL NOT affect the operation.
REQ-016 SHALL treat start as accepted only in IDLE with flush low; start in any other state SHALL be ignored.
REQ-017 SHALL assert busy in CALC and FIX, deassert in IDLE and DONE.
REQ-018 SHALL assert done (and div0 when applicable) exactly in DONE, i.e. the cycle WIDTH+2 after the start cycle (start cycle = 0), for all ops.
REQ-019 SHALL hold result and div0 stable from DONE until the next accepted start.
REQ-020 SHALL in CALC perform one magnitude bit per cycle: shift-add multiply for ops 0,1,4-7, restoring division for ops 2,3.
REQ-021 SHALL use magnitudes of op1/op2 for signed ops (0,2,4,6) and raw values for unsigned ops; |MIN| SHALL be the unsigned value 2^(WIDTH-1).
REQ-022 SHALL in FIX apply signs: product negated (2*WIDTH bits) when op1/op2 signs differ; quotient negated when signs differ; remainder takes the sign of op1.
REQ-023 SHALL produce MULT/MULTU result = full 2*WIDTH product.
REQ-024 SHALL produce MADD(U) = hilo_i + product and MSUB(U) = hilo_i - product, modulo 2^(2*WIDTH).
REQ-025 SHALL produce DIV/DIVU result = {remainder, quotient}.
REQ-026 SHALL on op2 == 0 for DIV/DIVU produce result = {op1, all ones} and div0 = 1, with unchanged latency.
REQ-027 SHALL for signed MIN / -1 produce quotient = MIN, remainder = 0, div0 = 0.
REQ-028 SHALL on flush high in any state return to IDLE at the next edge, with no done pulse and result unchanged.
REQ-029 SHALL give flush priority over start when both are high in IDLE (no operation accepted).
REQ-030 SHALL accept a new start in the cycle after DONE (back-to-back throughput one op per WIDTH+3 cycles).

Reset
REQ-031 SHALL on rst high immediately force IDLE, busy = 0, done = 0, div0 = 0, result = 0, independent of clk.
REQ-032 SHALL on rst asserted mid-operation discard the operation; no done pulse SHALL follow reset release.
REQ-033 SHALL accept start on the first rising edge after rst deasserts.

Verification (WIDTH = 32)
REQ-034 SHALL cover MULT op1=0xFFFFFFFE (-2), op2=3 -> done at cycle 34, result=0xFFFFFFFF_FFFFFFFA; MULTU same operands -> 0x00000002_FFFFFFFA.
REQ-035 SHALL cover DIV op1=-7, op2=2 -> result {hi=0xFFFFFFFF (-1), lo=0xFFFFFFFD (-3)}, div0=0; DIVU 7/2 -> {1, 3}.
REQ-036 SHALL cover DIVU op1=0x1234, op2=0 -> result {0x00001234, 0xFFFFFFFF}, div0=1 at cycle 34; DIV 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}, div0=0.
REQ-037 SHALL cover MADD hilo_i=0x00000000_00000010, op1=-1, op2=4 -> 0x00000000_0000000C; MSUBU hilo_i=0, op1=1, op2=1 -> 0xFFFFFFFF_FFFFFFFF.
REQ-038 SHALL cover flush at cycle 10 of a DIV -> busy low at cycle 11, no done; start+flush together in IDLE -> busy stays low.
REQ-039 SHALL cover rst pulse at cycle 5 of a MULT and start held during busy -> outputs zero immediately, no done; ignored start produces no second done.

Source files
------------

// File: rtl/multi_cycle_unit.sv
// multi_cycle_unit: iterative shift-add multiply / restoring divide with multiply-accumulate
module multi_cycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flush,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  input  logic [2*WIDTH-1:0]   hilo_i,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div0
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [2:0] op_q;
  logic [WIDTH-1:0] op1_q, b, mag1, mag2, q_s, r_s;
  logic [2*WIDTH-1:0] p, hilo_q, step, prod, fix_res;
  logic [WIDTH:0] sum, sh_r, diff;
  logic [CW-1:0] cnt;
  logic sgn, is_div, neg_p, neg_r, zero_q;
  assign sgn = ~op[0];
  assign is_div = op[2:1] == 2'b01;
  assign mag1 = (sgn && op1[WIDTH-1]) ? -op1 : op1;
  assign mag2 = (sgn && op2[WIDTH-1]) ? -op2 : op2;
  assign busy = state == CALC || state == FIX;
  assign done = state == DONE;
  always_comb begin
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b} : '0);
    sh_r = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    diff = sh_r - {1'b0, b};
    step = op_q[2:1] != 2'b01 ? {sum, p[WIDTH-1:1]} :
           diff[WIDTH] ? {sh_r[WIDTH-1:0], p[WIDTH-2:0], 1'b0} :
           {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    prod = neg_p ? -p : p;
    q_s = neg_p ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    r_s = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    fix_res = op_q[2:1] == 2'b01 ? (zero_q ? {op1_q, {WIDTH{1'b1}}} : {r_s, q_s}) :
              !op_q[2] ? prod :
              op_q[1] ? hilo_q - prod : hilo_q + prod;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      result <= '0;
      div0 <= 1'b0;
      op_q <= '0;
      op1_q <= '0;
      b <= '0;
      p <= '0;
      hilo_q <= '0;
      cnt <= '0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      zero_q <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= CALC;
          op_q <= op;
          op1_q <= op1;
          b <= mag2;
          p <= {{WIDTH{1'b0}}, mag1};
          hilo_q <= hilo_i;
          cnt <= '0;
          neg_p <= sgn & (op1[WIDTH-1] ^ op2[WIDTH-1]);
          neg_r <= sgn & op1[WIDTH-1];
          zero_q <= is_div && op2 == '0;
        end
        CALC: begin
          p <= step;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          div0 <= zero_q;
          state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_unit.sv
// tb_multi_cycle_unit: scoreboard bench for multi_cycle_unit
module tb_multi_cycle_unit;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0] op = '0;
  logic [W-1:0] op1 = '0, op2 = '0;
  logic [2*W-1:0] hilo_i = '0, result;
  logic busy, done, div0;
  typedef struct {
    logic [2*W-1:0] res;
    logic dz;
    int cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int cyc = 0, checks = 0, failures = 0;
  logic [2*W-1:0] last_res = '0;
  multi_cycle_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op), .op1(op1), .op2(op2),
    .hilo_i(hilo_i), .busy(busy), .done(done), .result(result), .div0(div0)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (done) begin
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
    end else begin
      e = sb.pop_front();
      chk("result", result, e.res);
      chk("div0", 64'(div0), 64'(e.dz));
      chk("done_cycle", 64'(cyc), 64'(e.cyc));
    end
  end
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] h, input logic [2*W-1:0] r, input logic dz);
    op = o; op1 = a; op2 = b; hilo_i = h; start = 1'b1;
    sb.push_back('{r, dz, cyc + W + 2});
    last_res = r;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; op1 = ~a; op2 = b + 1; hilo_i = ~h;
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
    #1;
  endtask
  task automatic idle_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_div0", 64'(div0), 64'(0));
    chk("rst_result", result, 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    issue(3'd0, 32'hFFFFFFFE, 32'd3, 64'd0, 64'hFFFFFFFF_FFFFFFFA, 1'b0); drain();
    issue(3'd1, 32'hFFFFFFFE, 32'd3, 64'd0, 64'h00000002_FFFFFFFA, 1'b0); drain();
    issue(3'd2, 32'hFFFFFFF9, 32'd2, 64'd0, 64'hFFFFFFFF_FFFFFFFD, 1'b0); drain();
    issue(3'd3, 32'd7, 32'd2, 64'd0, 64'h00000001_00000003, 1'b0); drain();
    issue(3'd3, 32'h1234, 32'd0, 64'd0, 64'h00001234_FFFFFFFF, 1'b1); drain();
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 64'd0, 64'h00000000_80000000, 1'b0); drain();
    issue(3'd2, 32'hFFFFFFF9, 32'd0, 64'd0, 64'hFFFFFFF9_FFFFFFFF, 1'b1); drain();
    issue(3'd2, 32'd100, 32'hFFFFFFF9, 64'd0, 64'h00000002_FFFFFFF2, 1'b0); drain();
    issue(3'd4, 32'hFFFFFFFF, 32'd4, 64'h10, 64'h00000000_0000000C, 1'b0); drain();
    issue(3'd7, 32'd1, 32'd1, 64'd0, 64'hFFFFFFFF_FFFFFFFF, 1'b0); drain();
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 64'hFFFFFFFE_00000001, 1'b0); drain();
    issue(3'd6, 32'hFFFFFFFD, 32'hFFFFFFFB, 64'h100, 64'h00000000_000000F1, 1'b0); drain();
    issue(3'd5, 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 1'b0); drain();
    issue(3'd0, 32'd9, 32'd9, 64'd0, 64'd81, 1'b0); drain();
    op = 3'd2; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 chk("busy_before_flush", 64'(busy), 64'(1));
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("busy_after_flush", 64'(busy), 64'(0));
    chk("result_after_flush", result, last_res);
    idle_wait(45);
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    chk("busy_start_flush", 64'(busy), 64'(0));
    idle_wait(40);
    op = 3'd0; op1 = 32'd5; op2 = 32'd6; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_div0", 64'(div0), 64'(0));
    chk("midrst_result", result, 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    idle_wait(40);
    chk("result_after_rst", result, 64'(0));
    op = 3'd0; op1 = 32'd7; op2 = 32'hFFFFFFFD; start = 1'b1;
    sb.push_back('{64'hFFFFFFFF_FFFFFFEB, 1'b0, cyc + W + 2});
    @(posedge clk); #1 op1 = 32'd1; op2 = 32'd1;
    repeat (8) @(posedge clk);
    #1 start = 1'b0;
    drain();
    idle_wait(5);
    issue(3'd3, 32'd1000, 32'd10, 64'd0, 64'h00000000_00000064, 1'b0); drain();
    idle_wait(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
